// File: rtl/multi_port_cell_alloc.sv
// multi_port_cell_alloc: packet-buffer cell allocator.
// Hands out cell IDs from a circular free list to one ingress client and
// accepts returned cells from FREE_PORT_NUM ports under round-robin arbitration.
// Optional feature macro: CELL_ALLOC_DOUBLE_FREE_CHECK_EN (drops and flags
// frees of cells that are not currently allocated).
module multi_port_cell_alloc #(
  parameter int unsigned CELL_NUM       = 64,
  parameter int unsigned CELL_ID_WIDTH  = $clog2(CELL_NUM),
  parameter int unsigned FREE_PORT_NUM  = 2,
  parameter int unsigned INTENSE_THRESH = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   alloc_mem_req,
  output logic [CELL_ID_WIDTH-1:0]               alloc_cell_id,
  output logic                                   alloc_mem_success,
  output logic                                   alloc_mem_intense,
  input  logic [FREE_PORT_NUM-1:0]               free_mem_req,
  output logic [FREE_PORT_NUM-1:0]               free_mem_ready,
  input  logic [FREE_PORT_NUM*CELL_ID_WIDTH-1:0] free_cell_id,
  output logic [CELL_ID_WIDTH:0]                 free_cell_count,
  output logic                                   init_done,
  output logic                                   free_err
);

  localparam int unsigned W   = CELL_ID_WIDTH;
  localparam int unsigned CW  = CELL_ID_WIDTH + 1;
  localparam int unsigned P   = FREE_PORT_NUM;
  localparam int unsigned RRW = (FREE_PORT_NUM > 1) ? $clog2(FREE_PORT_NUM) : 1;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mem [CELL_NUM];
  logic [W-1:0]    head_q, head_d;
  logic [W-1:0]    tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    init_cnt_q, init_cnt_d;
  logic [RRW-1:0]  rr_q, rr_d;
  logic            init_done_q;
  logic            intense_q;

  logic            pop;
  logic            grant;
  logic            push;
  logic            found;
  logic [RRW-1:0]  gnt_idx;
  logic [W-1:0]    push_id;
  logic            we;
  logic [W-1:0]    wdata;
  int              idx;

  // Allocation grant and show-ahead head of the free list
  always_comb begin
    pop           = alloc_mem_req && (count_q != '0) && init_done_q;
    alloc_cell_id = mem[head_q];
  end

  // Round-robin search for the first requesting port starting at rr_q
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    push_id = '0;
    for (int k = 0; k < int'(P); k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(P)) idx = idx - int'(P);
      if (!found && free_mem_req[RRW'(idx)]) begin
        found   = 1'b1;
        gnt_idx = RRW'(idx);
      end
    end
    for (int i = 0; i < int'(P); i++) begin
      if (RRW'(i) == gnt_idx) push_id = free_cell_id[i*W +: W];
    end
    // A full list only accepts a return when a pop frees a slot this cycle
    grant          = found && init_done_q && ((count_q != CW'(CELL_NUM)) || pop);
    free_mem_ready = grant ? (P'(1) << gnt_idx) : '0;
  end

`ifdef CELL_ALLOC_DOUBLE_FREE_CHECK_EN
  logic [CELL_NUM-1:0] alloc_map_q, alloc_map_d;
  logic                dup;
  logic                free_err_q;

  // Reject returns of cells that are not currently handed out
  always_comb begin
    dup         = grant && !alloc_map_q[push_id];
    push        = grant && !dup;
    alloc_map_d = alloc_map_q;
    if (pop)  alloc_map_d[alloc_cell_id] = 1'b1;
    if (push) alloc_map_d[push_id]       = 1'b0;
  end

  // Allocated-cell bitmap and one-cycle error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_map_q <= '0;
      free_err_q  <= 1'b0;
    end else begin
      alloc_map_q <= alloc_map_d;
      free_err_q  <= dup;
    end
  end

  assign free_err = free_err_q;
`else
  // Every granted return is pushed; the full guard prevents overflow
  always_comb begin
    push = grant;
  end

  assign free_err = 1'b0;
`endif

  // Next-state: initial fill of IDs, then run-time push/pop bookkeeping
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    init_cnt_d = init_cnt_q;
    rr_d       = rr_q;
    we         = 1'b0;
    wdata      = push_id;
    case (state_q)
      ST_INIT: begin
        we         = 1'b1;
        wdata      = init_cnt_q;
        tail_d     = tail_q + W'(1);
        count_d    = count_q + CW'(1);
        init_cnt_d = init_cnt_q + W'(1);
        if (init_cnt_q == W'(CELL_NUM - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pop) head_d = head_q + W'(1);
        if (push) begin
          we     = 1'b1;
          tail_d = tail_q + W'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (grant) begin
          rr_d = (gnt_idx == RRW'(P - 1)) ? '0 : gnt_idx + RRW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Pointers, count, arbiter pointer and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      init_cnt_q  <= '0;
      rr_q        <= '0;
      init_done_q <= 1'b0;
      intense_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      init_cnt_q  <= init_cnt_d;
      rr_q        <= rr_d;
      init_done_q <= (state_q == ST_RUN);
      intense_q   <= (state_q == ST_RUN) && (count_d <= CW'(INTENSE_THRESH));
    end
  end

  // Free-list storage, written at the tail
  always_ff @(posedge clk) begin
    if (!rst && we) mem[tail_q] <= wdata;
  end

  assign alloc_mem_success = pop;
  assign alloc_mem_intense = intense_q;
  assign free_cell_count   = count_q;
  assign init_done         = init_done_q;

endmodule
